// File: rtl/pp_pkg.sv
// Shared definitions for the partial-product row sequencer: state encoding
// and row-index width helper.
package pp_pkg;

  typedef logic [0:0] state_t;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  // Row-index width; never below one bit so a 2-bit operand still indexes.
  function automatic int unsigned idx_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/pp_row_gen.sv
// Combinational row former: the multiplicand gated by one multiplier bit.
module pp_row_gen #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] row
);

  assign row = b & {WIDTH{sel}};

endmodule

// File: rtl/pp_row_sequencer.sv
// Streams the partial-product rows of a*b, one row per handshake.
// Build option: define PP_SKIP_ZERO_EN to emit only rows where a[idx]=1.
module pp_row_sequencer
  import pp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             pp_valid,
  input  logic             pp_ready,
  output logic [WIDTH-1:0] pp_row,
  output logic [IDX_W-1:0] pp_idx,
  output logic             pp_last,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             accept_c;
  logic             take_row_c;
  logic             last_c;
  logic [IDX_W-1:0] first_idx_c;
  logic [IDX_W-1:0] next_idx_c;
  logic             sel_c;

`ifdef PP_SKIP_ZERO_EN
  logic [WIDTH-1:0] rest_c;

  // Priority encoder: index of the lowest set bit, 0 when none is set.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Bits of a still to be emitted, strictly above the current row.
  always_comb begin
    rest_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      rest_c[i] = a_q[i] & (IDX_W'(i) > idx_q);
    end
  end

  assign first_idx_c = lowest_set(a);
  assign next_idx_c  = lowest_set(rest_c);
  assign last_c      = (rest_c == '0);
`else
  assign first_idx_c = '0;
  assign next_idx_c  = idx_q + IDX_W'(1);
  assign last_c      = (idx_q == IDX_W'(WIDTH - 1));
`endif

  assign pp_valid   = (state_q == EMIT);
  assign busy       = (state_q == EMIT);
  assign take_row_c = pp_valid & pp_ready;
  assign in_ready   = (state_q == IDLE) | (take_row_c & last_c);
  assign accept_c   = in_valid & in_ready;
  assign pp_idx     = idx_q;
  assign pp_last    = busy & last_c;
  assign sel_c      = busy & a_q[idx_q];

  pp_row_gen #(
    .WIDTH (WIDTH)
  ) u_row_gen (
    .b   (b_q),
    .sel (sel_c),
    .row (pp_row)
  );

  // Next-state logic; operand and index registers are cleared on return to IDLE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = EMIT;
          a_d     = a;
          b_d     = b;
          idx_d   = first_idx_c;
        end
      end
      EMIT: begin
        if (take_row_c) begin
          if (last_c) begin
            if (accept_c) begin
              a_d   = a;
              b_d   = b;
              idx_d = first_idx_c;
            end else begin
              state_d = IDLE;
              a_d     = '0;
              b_d     = '0;
              idx_d   = '0;
            end
          end else begin
            idx_d = next_idx_c;
          end
        end
      end
      default: begin
        state_d = IDLE;
        a_d     = '0;
        b_d     = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_pp_row_sequencer.sv
// Directed self-checking bench for pp_row_sequencer at WIDTH=8.
module tb_pp_row_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       pp_valid;
  logic       pp_ready;
  logic [7:0] pp_row;
  logic [2:0] pp_idx;
  logic       pp_last;
  logic       busy;

  int tests;
  int fails;

  logic [7:0]  rows_a5[8];
  logic [12:0] obs;
  logic [12:0] exp_v;

  pp_row_sequencer #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .pp_valid (pp_valid),
    .pp_ready (pp_ready),
    .pp_row   (pp_row),
    .pp_idx   (pp_idx),
    .pp_last  (pp_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    tests++;
    if ({pp_valid, busy, pp_idx, pp_row, pp_last} !== 14'h0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b busy=%b idx=%0d row=%h last=%b, want all 0",
               pp_valid, busy, pp_idx, pp_row, pp_last);
    end
    rst = 1'b0;
    step();
    tests++;
    if ({in_ready, busy, pp_valid} !== 3'b100) begin
      fails++;
      $display("FAIL reset_release: got in_ready=%b busy=%b v=%b, want 1 0 0", in_ready, busy, pp_valid);
    end
  endtask

`ifndef PP_SKIP_ZERO_EN
  task automatic check_idle(input string name);
    tests++;
    if ({pp_valid, busy, in_ready, pp_idx, pp_row, pp_last} !== {3'b001, 12'h0}) begin
      fails++;
      $display("FAIL %s_idle: got v=%b busy=%b in_ready=%b idx=%0d row=%h last=%b, want 0 0 1 0 00 0",
               name, pp_valid, busy, in_ready, pp_idx, pp_row, pp_last);
    end
  endtask

  task automatic test_basic();
    a = 8'hA5; b = 8'h3C; in_valid = 1'b1; pp_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      obs   = {pp_valid, pp_idx, pp_row, pp_last};
      exp_v = {1'b1, 3'(k), rows_a5[k], (k == 7)};
      tests++;
      if (obs !== exp_v || in_ready !== (k == 7)) begin
        fails++;
        $display("FAIL basic_row%0d: got {v,idx,row,last}=%h in_ready=%b, want %h in_ready=%b",
                 k, obs, in_ready, exp_v, (k == 7));
      end
      step();
    end
    check_idle("basic");
  endtask

  task automatic test_stall();
    a = 8'hA5; b = 8'h3C; in_valid = 1'b1; pp_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    pp_ready = 1'b0;
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF;
    for (int s = 0; s < 4; s++) begin
      obs = {pp_valid, pp_idx, pp_row, pp_last};
      tests++;
      if (obs !== {1'b1, 3'd2, 8'h3C, 1'b0} || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold%0d: got {v,idx,row,last}=%h in_ready=%b, want %h in_ready=0",
                 s, obs, in_ready, {1'b1, 3'd2, 8'h3C, 1'b0});
      end
      step();
    end
    in_valid = 1'b0;
    pp_ready = 1'b1;
    #1;
    for (int k = 2; k < 8; k++) begin
      obs   = {pp_valid, pp_idx, pp_row, pp_last};
      exp_v = {1'b1, 3'(k), rows_a5[k], (k == 7)};
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL stall_resume%0d: got {v,idx,row,last}=%h, want %h", k, obs, exp_v);
      end
      step();
    end
    check_idle("stall");
  endtask

  task automatic test_back_to_back();
    a = 8'hFF; b = 8'h01; in_valid = 1'b1; pp_ready = 1'b1;
    step();
    a = 8'h01; b = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      obs   = {pp_valid, pp_idx, pp_row, pp_last};
      exp_v = {1'b1, 3'(k), 8'h01, (k == 7)};
      tests++;
      if (obs !== exp_v || in_ready !== (k == 7)) begin
        fails++;
        $display("FAIL b2b_first%0d: got {v,idx,row,last}=%h in_ready=%b, want %h in_ready=%b",
                 k, obs, in_ready, exp_v, (k == 7));
      end
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      obs   = {pp_valid, pp_idx, pp_row, pp_last};
      exp_v = {1'b1, 3'(k), (k == 0) ? 8'hFF : 8'h00, (k == 7)};
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL b2b_second%0d: got {v,idx,row,last}=%h, want %h", k, obs, exp_v);
      end
      step();
    end
    check_idle("b2b");
  endtask

  task automatic test_reset_mid();
    a = 8'hA5; b = 8'h3C; in_valid = 1'b1; pp_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    obs = {pp_valid, pp_idx, pp_row, pp_last};
    tests++;
    if (obs !== {1'b1, 3'd4, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL rstmid_pre: got {v,idx,row,last}=%h, want %h", obs, {1'b1, 3'd4, 8'h00, 1'b0});
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({pp_valid, busy, pp_idx, pp_row, pp_last} !== 14'h0) begin
      fails++;
      $display("FAIL rstmid_async: got v=%b busy=%b idx=%0d row=%h last=%b, want all 0",
               pp_valid, busy, pp_idx, pp_row, pp_last);
    end
    step();
    rst = 1'b0;
    #1;
    check_idle("rstmid");
    step();
    tests++;
    if (pp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_no_rows: got pp_valid=%b, want 0", pp_valid);
    end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    obs = {pp_valid, pp_idx, pp_row, pp_last};
    tests++;
    if (obs !== {1'b1, 3'd0, 8'h3C, 1'b0}) begin
      fails++;
      $display("FAIL rstmid_restart: got {v,idx,row,last}=%h, want %h", obs, {1'b1, 3'd0, 8'h3C, 1'b0});
    end
    repeat (8) step();
    check_idle("rstmid_done");
  endtask
`else
  task automatic test_skip_zero();
    a = 8'h90; b = 8'h7E; in_valid = 1'b1; pp_ready = 1'b1;
    step();
    in_valid = 1'b0;
    obs = {pp_valid, pp_idx, pp_row, pp_last};
    tests++;
    if (obs !== {1'b1, 3'd4, 8'h7E, 1'b0}) begin
      fails++;
      $display("FAIL skip_row4: got %h, want %h", obs, {1'b1, 3'd4, 8'h7E, 1'b0});
    end
    step();
    obs = {pp_valid, pp_idx, pp_row, pp_last};
    tests++;
    if (obs !== {1'b1, 3'd7, 8'h7E, 1'b1}) begin
      fails++;
      $display("FAIL skip_row7: got %h, want %h", obs, {1'b1, 3'd7, 8'h7E, 1'b1});
    end
    step();
    tests++;
    if ({pp_valid, busy} !== 2'b00) begin
      fails++;
      $display("FAIL skip_idle: got v=%b busy=%b, want 0 0", pp_valid, busy);
    end
    a = 8'h00; b = 8'h7E; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    obs = {pp_valid, pp_idx, pp_row, pp_last};
    tests++;
    if (obs !== {1'b1, 3'd0, 8'h00, 1'b1}) begin
      fails++;
      $display("FAIL skip_zero_a: got %h, want %h", obs, {1'b1, 3'd0, 8'h00, 1'b1});
    end
    step();
    tests++;
    if ({pp_valid, busy, in_ready} !== 3'b001) begin
      fails++;
      $display("FAIL skip_zero_idle: got v=%b busy=%b in_ready=%b, want 0 0 1", pp_valid, busy, in_ready);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    rows_a5 = '{8'h3C, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h3C};
    rst = 1'b1; in_valid = 1'b0; pp_ready = 1'b0; a = 8'h00; b = 8'h00;
    test_reset();
`ifndef PP_SKIP_ZERO_EN
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`else
    test_skip_zero();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
